delay_ctrl: RTL and testbench
=============================

DELAY_CTRL -- requirements
Module: delay_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 16, sample data width in bits.
REQ-002 SHALL have parameter MAX_DEPTH, default 1024, word count of the external circular RAM; any integer >= 4, power of two not required.
REQ-003 SHALL have localparam AW = log2(MAX_DEPTH), the width of every RAM address and depth field.
REQ-004 SHALL have port clk  input  1  clock; all logic on rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port cfg_depth  input  AW  requested delay D, in accepted samples.
REQ-007 SHALL have port cfg_load  input  1  one-cycle pulse that latches cfg_depth and restarts the delay line.
REQ-008 SHALL have port cfg_err  output  1  one-cycle pulse when the latched cfg_depth was clamped.
REQ-009 SHALL have port in_valid  input  1  input sample qualifier; there is no backpressure.
REQ-010 SHALL have port in_data  input  WIDTH  input sample.
REQ-011 SHALL have ports ram_we  output  1,  ram_waddr  output  AW,  ram_wdata  output  WIDTH: RAM write port.
REQ-012 SHALL have ports ram_re  output  1,  ram_raddr  output  AW: RAM read port.
REQ-013 SHALL have port ram_rdata  input  WIDTH  RAM read data, valid exactly 1 cycle after ram_re.
REQ-014 SHALL have port out_valid  output  1  delayed-sample qualifier.
REQ-015 SHALL have port out_data  output  WIDTH  delayed sample; equals ram_rdata whenever out_valid = 1.
REQ-016 SHALL have port state  output  2  current FSM state: 0 IDLE, 1 FILL, 2 RUN.
REQ-017 SHALL have port fill_level  output  AW  count of samples accepted in FILL, saturating at D.

Function
REQ-018 SHALL implement FSM states IDLE, FILL and RUN.
REQ-019 In IDLE, SHALL ignore in_valid and hold ram_we = ram_re = 0.
REQ-020 On cfg_load in any state, SHALL latch D_eff = clamp(cfg_depth, 1, MAX_DEPTH-1), clear wr_ptr and fill_level to 0, and enter FILL next cycle.
REQ-021 When cfg_load latches a value with cfg_depth = 0 or cfg_depth > MAX_DEPTH-1, SHALL pulse cfg_err the following cycle; otherwise cfg_err stays 0.
REQ-022 SHALL treat a sample as accepted when in_valid = 1, state is FILL or RUN, and cfg_load = 0; cfg_load wins over a simultaneous in_valid, and that sample is dropped.
REQ-023 On each accepted sample, SHALL drive the write combinationally in the same cycle: ram_we = 1, ram_waddr = wr_ptr, ram_wdata = in_data; wr_ptr then increments, wrapping MAX_DEPTH-1 -> 0.
REQ-024 In FILL, SHALL increment fill_level on each accepted sample; in the cycle fill_level == D_eff, SHALL transition to RUN.
REQ-025 In RUN, for each accepted sample, SHALL assert ram_re = 1 with ram_raddr = (wr_ptr - D_eff) mod MAX_DEPTH, computed with an explicit add-back of MAX_DEPTH on underflow.
REQ-026 SHALL assert out_valid as ram_re delayed 1 cycle, so the accepted sample k produces output sample k-D_eff on the next cycle.
REQ-027 SHALL never issue a read in FILL, so no stale or uninitialised RAM word reaches out_valid.
REQ-028 On cfg_load, SHALL force out_valid = 0 the following cycle, suppressing any read in flight.
REQ-029 SHALL preserve order and deliver exactly one output per accepted sample in RUN; gaps in in_valid produce matching gaps in out_valid.
REQ-030 Since D_eff <= MAX_DEPTH-1, ram_raddr SHALL never equal ram_waddr in the same cycle; no RAM read-during-write mode is required.

Reset
REQ-031 On rst, SHALL set state = IDLE, wr_ptr = 0, fill_level = 0, D_eff = 1, and all outputs to 0 (out_data 0, cfg_err 0).
REQ-032 rst SHALL override cfg_load and in_valid in the same cycle.
REQ-033 A rst asserted mid-RUN SHALL suppress any pending out_valid.

Verification
REQ-034 Stream test: rst, cfg_depth=4 load, continuous samples 0..11 -> ram_re first asserts on sample 4, out_valid from the next cycle with out_data 0..7, state 1 -> 2.
REQ-035 Gapped test: D=3, in_valid every other cycle with data 10,11,12,... -> out_valid follows only accepted samples, giving 10,11,12,... with no duplicates.
REQ-036 Wrap test: MAX_DEPTH=8, D=7, 30 samples -> waddr wraps 7 -> 0, raddr follows (wr_ptr-7) mod 8, every output equals its input minus 7.
REQ-037 Clamp test: cfg_depth=0 -> D_eff=1 with a cfg_err pulse; MAX_DEPTH=8 with cfg_depth=9 (AW=3 truncation excluded, use cfg_depth=7 as legal) -> cfg_err low; illegal values give D_eff=7.
REQ-038 Reconfigure test: D=4 in RUN, cfg_load D=2 with in_valid=1 in the same cycle -> sample dropped, out_valid low until 2 new samples accepted, first output is the first new sample.
REQ-039 Reset test: rst mid-RUN with a read in flight -> next cycle out_valid=0, state=0, and in_valid ignored until cfg_load.

Source files
------------

// File: rtl/delay_ctrl.sv
// Programmable delay line over an external circular RAM.
// Samples are written at wr_ptr and read back D_eff samples later once the line has filled.
module delay_ctrl #(
   parameter  int WIDTH     = 16,
   parameter  int MAX_DEPTH = 1024,
   localparam int AW        = $clog2(MAX_DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [AW-1:0]    cfg_depth,
   input  logic             cfg_load,
   output logic             cfg_err,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] in_data,
   output logic             ram_we,
   output logic [AW-1:0]    ram_waddr,
   output logic [WIDTH-1:0] ram_wdata,
   output logic             ram_re,
   output logic [AW-1:0]    ram_raddr,
   input  logic [WIDTH-1:0] ram_rdata,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_data,
   output logic [1:0]       state,
   output logic [AW-1:0]    fill_level
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      FILL = 2'd1,
      RUN  = 2'd2
   } state_t;

   localparam logic [AW-1:0] ONE     = AW'(1);
   localparam logic [AW-1:0] LAST    = AW'(MAX_DEPTH - 1);
   localparam logic [AW:0]   DMAX    = (AW+1)'(MAX_DEPTH - 1);
   localparam logic [AW:0]   DEPTH_W = (AW+1)'(MAX_DEPTH);

   state_t        cur, nxt;
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] fill_cnt;
   logic [AW-1:0] d_eff;
   logic [AW-1:0] d_clamp;
   logic          bad_depth;
   logic          accept;
   logic          rd;
   logic          re_q;
   logic          err_q;
   logic [AW:0]   diff;
   logic [AW:0]   raddr_w;

   // Depth is clamped into [1, MAX_DEPTH-1] so a read never aliases the write slot.
   always_comb begin
      bad_depth = 1'b0;
      d_clamp   = cfg_depth;
      if (cfg_depth == '0) begin
         bad_depth = 1'b1;
         d_clamp   = ONE;
      end else if ({1'b0, cfg_depth} > DMAX) begin
         bad_depth = 1'b1;
         d_clamp   = LAST;
      end
   end

   // State register
   always_ff @(posedge clk) begin
      if (rst) cur <= IDLE;
      else     cur <= nxt;
   end

   // Next-state logic; FILL ends on the sample that brings the fill level up to D_eff
   always_comb begin
      nxt = cur;
      if (cfg_load) begin
         nxt = FILL;
      end else begin
         case (cur)
            FILL:    if (accept && (fill_cnt == d_eff - ONE)) nxt = RUN;
            RUN:     nxt = RUN;
            default: nxt = IDLE;
         endcase
      end
   end

   // Output logic: RAM strobes are combinational in the accepting cycle
   always_comb begin
      accept    = in_valid && !rst && !cfg_load && ((cur == FILL) || (cur == RUN));
      rd        = accept && (cur == RUN);
      diff      = {1'b0, wr_ptr} - {1'b0, d_eff};
      raddr_w   = diff[AW] ? (diff + DEPTH_W) : diff;
      ram_we    = accept;
      ram_waddr = accept ? wr_ptr : '0;
      ram_wdata = accept ? in_data : '0;
      ram_re    = rd;
      ram_raddr = rd ? raddr_w[AW-1:0] : '0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr   <= '0;
         fill_cnt <= '0;
         d_eff    <= ONE;
         re_q     <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         err_q <= cfg_load && bad_depth;
         re_q  <= rd;
         if (cfg_load) begin
            d_eff    <= d_clamp;
            wr_ptr   <= '0;
            fill_cnt <= '0;
         end else if (accept) begin
            wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + ONE;
            if ((cur == FILL) && (fill_cnt != d_eff))
               fill_cnt <= fill_cnt + ONE;
         end
      end
   end

   assign cfg_err    = err_q;
   assign out_valid  = re_q;
   assign out_data   = re_q ? ram_rdata : '0;
   assign state      = cur;
   assign fill_level = fill_cnt;

endmodule

// File: tb/tb_delay_ctrl.sv
// Bench for delay_ctrl: constant vector table, directed corner sequences and a
// randomized run checked against a sample-history model of the delay line.
module tb_delay_ctrl;
   localparam int W  = 16;
   localparam int M  = 8;
   localparam int AW = 3;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst, cfg_load, in_valid, cfg_err, ram_we, ram_re, out_valid;
   logic [AW-1:0] cfg_depth, ram_waddr, ram_raddr, fill_level;
   logic [W-1:0]  in_data, ram_wdata, ram_rdata, out_data;
   logic [1:0]    state;

   delay_ctrl #(.WIDTH(W), .MAX_DEPTH(M)) dut (
      .clk(clk), .rst(rst), .cfg_depth(cfg_depth), .cfg_load(cfg_load), .cfg_err(cfg_err),
      .in_valid(in_valid), .in_data(in_data), .ram_we(ram_we), .ram_waddr(ram_waddr),
      .ram_wdata(ram_wdata), .ram_re(ram_re), .ram_raddr(ram_raddr), .ram_rdata(ram_rdata),
      .out_valid(out_valid), .out_data(out_data), .state(state), .fill_level(fill_level)
   );

   logic [W-1:0] mem [M];
   always @(posedge clk) begin
      if (ram_we) mem[ram_waddr] <= ram_wdata;
      if (ram_re) ram_rdata <= mem[ram_raddr];
   end

   // Second instance with a non-power-of-two depth to reach the upper clamp.
   logic          b_rst, b_load, b_valid, b_err, b_we, b_re, b_ov;
   logic [2:0]    b_depth, b_waddr, b_raddr, b_fill;
   logic [7:0]    b_data, b_wdata, b_rdata, b_odata;
   logic [1:0]    b_state;
   assign b_rdata = 8'h00;

   delay_ctrl #(.WIDTH(8), .MAX_DEPTH(6)) dut_b (
      .clk(clk), .rst(b_rst), .cfg_depth(b_depth), .cfg_load(b_load), .cfg_err(b_err),
      .in_valid(b_valid), .in_data(b_data), .ram_we(b_we), .ram_waddr(b_waddr),
      .ram_wdata(b_wdata), .ram_re(b_re), .ram_raddr(b_raddr), .ram_rdata(b_rdata),
      .out_valid(b_ov), .out_data(b_odata), .state(b_state), .fill_level(b_fill)
   );

   int tests = 0;
   int fails = 0;

   task automatic chk(input string nm, input int act, input int exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   // Model: history of samples accepted since the last load; output k is sample k-D.
   bit mv = 1'b0;
   bit m_act;
   int m_n, m_d, e_od;
   bit e_ov, e_err;
   int hist[$];
   int outs[$];

   task automatic cyc(input bit r, input bit l, input int dep, input bit v, input int d);
      bit acc, rd;
      int es, ef;
      @(negedge clk);
      rst = r; cfg_load = l; cfg_depth = dep[AW-1:0]; in_valid = v; in_data = d[W-1:0];
      #1;
      acc = !r && !l && m_act && v;
      rd  = acc && (m_n >= m_d);
      chk("ram_we", ram_we, acc);
      chk("ram_waddr", ram_waddr, acc ? m_n % M : 0);
      chk("ram_wdata", ram_wdata, acc ? d : 0);
      chk("ram_re", ram_re, rd);
      chk("ram_raddr", ram_raddr, rd ? (m_n - m_d) % M : 0);
      if (mv) begin
         es = !m_act ? 0 : ((m_n >= m_d) ? 2 : 1);
         ef = (m_n < m_d) ? m_n : m_d;
         chk("state", state, es);
         chk("fill_level", fill_level, ef);
         chk("out_valid", out_valid, e_ov);
         chk("out_data", out_data, e_ov ? e_od : 0);
         chk("cfg_err", cfg_err, e_err);
      end
      if (out_valid) outs.push_back(int'(out_data));
      if (r) begin
         mv = 1'b1; m_act = 1'b0; m_n = 0; m_d = 1; hist.delete(); e_ov = 1'b0; e_err = 1'b0;
      end else if (l) begin
         m_d   = (dep == 0) ? 1 : ((dep > M-1) ? M-1 : dep);
         e_err = (dep == 0) || (dep > M-1);
         m_act = 1'b1; m_n = 0; hist.delete(); e_ov = 1'b0;
      end else begin
         e_err = 1'b0;
         e_ov  = rd;
         if (acc) begin
            hist.push_back(d);
            if (rd) e_od = hist[m_n - m_d];
            m_n++;
         end
      end
   endtask

   typedef struct {
      bit l; int dep; bit v; int d;
      int st; int we; int re; int ov; int od; int fl;
   } vec_t;
   vec_t tbl[16];

   initial begin
      #2_000_000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      int first_re;
      rst = 1'b1; cfg_load = 1'b0; cfg_depth = '0; in_valid = 1'b0; in_data = '0;
      b_rst = 1'b1; b_load = 1'b0; b_depth = '0; b_valid = 1'b0; b_data = '0;

      // Upper clamp on MAX_DEPTH=6: depth 7 -> D_eff 5 with error pulse
      repeat (2) @(negedge clk);
      b_rst = 1'b0; b_load = 1'b1; b_depth = 3'd7;
      @(negedge clk);
      b_load = 1'b0;
      #1 chk("b_err_clamp", b_err, 1);
      first_re = -1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         b_valid = 1'b1; b_data = 8'(i);
         #1;
         if (i == 0) chk("b_err_pulse_end", b_err, 0);
         if (b_re && first_re < 0) begin
            first_re = i;
            chk("b_raddr_first", b_raddr, 0);
         end
      end
      chk("b_first_re", first_re, 5);
      @(negedge clk);
      b_valid = 1'b0; b_load = 1'b1; b_depth = 3'd5;
      @(negedge clk);
      b_load = 1'b0;
      #1 chk("b_err_legal", b_err, 0);
      @(negedge clk);
      b_load = 1'b1; b_depth = 3'd6;
      @(negedge clk);
      b_load = 1'b0;
      #1 chk("b_err_6", b_err, 1);

      // Stream test, D=4, as a constant vector table
      cyc(1, 0, 0, 0, 0);
      cyc(1, 0, 0, 1, 5);
      tbl[0]  = '{0, 0, 1, 99, 0, 0, 0, 0, 0, 0};
      tbl[1]  = '{1, 4, 1, 98, 0, 0, 0, 0, 0, 0};
      tbl[2]  = '{0, 0, 1, 0,  1, 1, 0, 0, 0, 0};
      tbl[3]  = '{0, 0, 1, 1,  1, 1, 0, 0, 0, 1};
      tbl[4]  = '{0, 0, 1, 2,  1, 1, 0, 0, 0, 2};
      tbl[5]  = '{0, 0, 1, 3,  1, 1, 0, 0, 0, 3};
      tbl[6]  = '{0, 0, 1, 4,  2, 1, 1, 0, 0, 4};
      for (int k = 5; k <= 11; k++) tbl[k+2] = '{0, 0, 1, k, 2, 1, 1, 1, k-5, 4};
      tbl[14] = '{0, 0, 0, 0,  2, 0, 0, 1, 7, 4};
      tbl[15] = '{0, 0, 0, 0,  2, 0, 0, 0, 0, 4};
      for (int i = 0; i < 16; i++) begin
         cyc(0, tbl[i].l, tbl[i].dep, tbl[i].v, tbl[i].d);
         chk("tbl_state", state, tbl[i].st);
         chk("tbl_we", ram_we, tbl[i].we);
         chk("tbl_re", ram_re, tbl[i].re);
         chk("tbl_ov", out_valid, tbl[i].ov);
         chk("tbl_od", out_data, tbl[i].od);
         chk("tbl_fill", fill_level, tbl[i].fl);
      end

      // Gapped input, D=3
      cyc(0, 1, 3, 0, 0);
      outs.delete();
      for (int i = 0; i < 20; i++) begin
         cyc(0, 0, 0, 1, 10 + i);
         cyc(0, 0, 0, 0, 0);
      end
      cyc(0, 0, 0, 0, 0);
      chk("gap_count", outs.size(), 17);
      foreach (outs[j]) chk("gap_data", outs[j], 10 + j);

      // Pointer wrap, D=7
      cyc(0, 1, 7, 0, 0);
      outs.delete();
      for (int i = 0; i < 30; i++) cyc(0, 0, 0, 1, 100 + i);
      cyc(0, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 0);
      chk("wrap_count", outs.size(), 23);
      foreach (outs[j]) chk("wrap_data", outs[j], 100 + j);

      // Lower clamp: depth 0 -> D_eff 1
      cyc(0, 1, 0, 0, 0);
      cyc(0, 0, 0, 1, 50);
      chk("clamp0_err", cfg_err, 1);
      chk("clamp0_fill_re", ram_re, 0);
      cyc(0, 0, 0, 1, 51);
      chk("clamp0_re", ram_re, 1);
      chk("clamp0_raddr", ram_raddr, 0);
      cyc(0, 1, 7, 0, 0);
      cyc(0, 0, 0, 0, 0);
      chk("legal7_err", cfg_err, 0);

      // Reconfigure mid-RUN with a simultaneous sample
      cyc(0, 1, 4, 0, 0);
      for (int i = 0; i < 6; i++) cyc(0, 0, 0, 1, 200 + i);
      cyc(0, 1, 2, 1, 300);
      chk("reload_drop_we", ram_we, 0);
      outs.delete();
      for (int i = 1; i <= 4; i++) cyc(0, 0, 0, 1, 300 + i);
      cyc(0, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 0);
      chk("reload_count", outs.size(), 2);
      if (outs.size() > 0) chk("reload_first", outs[0], 301);

      // Reset with a read in flight
      cyc(0, 1, 2, 0, 0);
      for (int i = 0; i < 5; i++) cyc(0, 0, 0, 1, 400 + i);
      cyc(1, 0, 0, 1, 500);
      chk("rst_we", ram_we, 0);
      cyc(0, 0, 0, 1, 501);
      chk("rst_ov", out_valid, 0);
      chk("rst_state", state, 0);
      chk("rst_idle_we", ram_we, 0);
      cyc(0, 0, 0, 1, 502);
      chk("rst_idle_we2", ram_we, 0);

      // Randomized traffic
      cyc(0, 1, 3, 0, 0);
      for (int i = 0; i < 800; i++) begin
         cyc($urandom_range(0, 149) == 0, $urandom_range(0, 39) == 0, $urandom_range(0, 7),
             $urandom_range(0, 3) != 0, $urandom_range(0, 65535));
         if (!m_act && $urandom_range(0, 3) == 0) cyc(0, 1, $urandom_range(0, 7), 1, 0);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
